// File: rtl/uart_tx_byte.sv
// uart_tx_byte: byte-serial asynchronous transmitter for the status logger.
// Each byte accepted on the Uart_En/Uart_Busy handshake becomes one 8N1 frame
// on UART_TX, LSB first. There is no buffering: a byte offered while a frame
// is in flight is discarded and reported on Uart_Drop.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1).
// Every output is a flop; the next-state logic computes each output's value
// for the coming cycle, so nothing combinational reaches a port.
module uart_tx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       CLK_SYS,
    input  logic       CLK_RST,
    input  logic       Uart_En,
    input  logic [7:0] Uart_Data,
    output logic       Uart_Busy,
    output logic       UART_TX,
    output logic       Uart_Done,
    output logic       Uart_Drop
);

    // Clock cycles per bit, rounded to the nearest integer.
    localparam int          BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

    // Refuse to build with a divider the 16-bit counter cannot represent, or
    // one too short to give Uart_Done its own cycle inside the stop bit.
    generate
        if (BAUD_DIV < 2 || BAUD_DIV > 65536) begin : g_baud_div_check
            $error("uart_tx_byte: BAUD_DIV must lie in 2..65536");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t      state_q, state_n;
    logic [15:0] cnt_q, cnt_n;
    logic [2:0]  idx_q, idx_n;
    logic [7:0]  shift_q, shift_n;
    logic        tx_q, tx_n;
    logic        busy_q;
    logic        done_q;
    logic        drop_q;
    logic        done_n;
    logic        drop_n;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_n;
`endif

    assign bit_end = (cnt_q == DIV_LAST);

    // Next-state, next-output and datapath update for the frame sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        shift_n = shift_q;
        tx_n    = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_n = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                tx_n  = 1'b1;
                if (Uart_En && !busy_q) begin
                    state_n = ST_START;
                    shift_n = Uart_Data;
                    tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_n = ^Uart_Data;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_DATA;
                    tx_n    = shift_q[0];
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx_q == 3'd7) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = ST_PARITY;
                        tx_n    = parity_q;
`else
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        idx_n   = idx_q + 3'd1;
                        shift_n = {1'b0, shift_q[7:1]};
                        tx_n    = shift_q[1];
                    end
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_STOP;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                tx_n    = 1'b1;
            end
        endcase

        // Done flags the final cycle of the stop bit; drop flags a byte
        // offered while the line is owned by a frame.
        done_n = (state_n == ST_STOP) && (cnt_n == DIV_LAST);
        drop_n = Uart_En && busy_q;
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            // NOTE: the shift register is reset along with the control state;
            // it is only eight flops and keeps simulation free of X on the
            // datapath after reset.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shift_q <= shift_n;
            tx_q    <= tx_n;
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= done_n;
            drop_q  <= drop_n;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

    assign UART_TX   = tx_q;
    assign Uart_Busy = busy_q;
    assign Uart_Done = done_q;
    assign Uart_Drop = drop_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte at BAUD_DIV = 10 (50 MHz / 5 Mbit/s).
// Outputs are sampled 1 ns after each rising edge into per-period vectors;
// index 0 is the first cycle after the accept edge.
`timescale 1ns/1ps
module tb_uart_tx_byte;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 5_000_000;
    localparam int DIV      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif
    localparam int VW = 300;
    typedef logic [VW-1:0] vec_t;

    logic       CLK_SYS   = 1'b0;
    logic       CLK_RST   = 1'b0;
    logic       Uart_En   = 1'b0;
    logic [7:0] Uart_Data = 8'h00;
    logic       Uart_Busy;
    logic       UART_TX;
    logic       Uart_Done;
    logic       Uart_Drop;

    int total = 0;
    int bad   = 0;

    vec_t tx_v, busy_v, done_v, drop_v;

    uart_tx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .CLK_SYS   (CLK_SYS),
        .CLK_RST   (CLK_RST),
        .Uart_En   (Uart_En),
        .Uart_Data (Uart_Data),
        .Uart_Busy (Uart_Busy),
        .UART_TX   (UART_TX),
        .Uart_Done (Uart_Done),
        .Uart_Drop (Uart_Drop)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    // Record n periods of outputs; drive En/Data for the next edge after each sample.
    task automatic capture(input int n, input int pulse_idx, input logic [7:0] pulse_data,
                           input bit hold_en, input bit scramble);
        tx_v = '0; busy_v = '0; done_v = '0; drop_v = '0;
        for (int i = 0; i < n; i++) begin
            tx_v[i]   = UART_TX;
            busy_v[i] = Uart_Busy;
            done_v[i] = Uart_Done;
            drop_v[i] = Uart_Drop;
            Uart_En   = hold_en || (i == pulse_idx);
            if (scramble)             Uart_Data = 8'($urandom);
            else if (i == pulse_idx)  Uart_Data = pulse_data;
            tick();
        end
    endtask

    task automatic send_pulse(input logic [7:0] b);
        Uart_En   = 1'b1;
        Uart_Data = b;
        tick();
        Uart_En   = 1'b0;
    endtask

    function automatic vec_t mask_n(input int n);
        vec_t m = '0;
        for (int i = 0; i < n && i < VW; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Expected line levels of one frame of byte b starting at period s.
    function automatic vec_t add_tx(input vec_t v, input int s, input logic [7:0] b);
        vec_t r = v;
        for (int j = 0; j < DIV; j++) begin
            if (s + j < VW) r[s + j] = 1'b0;
            for (int k = 0; k < 8; k++)
                if (s + (k + 1) * DIV + j < VW) r[s + (k + 1) * DIV + j] = b[k];
`ifdef UART_TX_PARITY_EN
            if (s + 9 * DIV + j < VW) r[s + 9 * DIV + j] = ^b;
`endif
        end
        return r;
    endfunction

    function automatic vec_t add_busy(input vec_t v, input int s);
        vec_t r = v;
        for (int j = 0; j < FRAME; j++) if (s + j < VW) r[s + j] = 1'b1;
        return r;
    endfunction

    function automatic vec_t add_one(input vec_t v, input int idx);
        vec_t r = v;
        if (idx >= 0 && idx < VW) r[idx] = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        Uart_En = 1'b0;
        CLK_RST = 1'b0;
        repeat (3) tick();
        CLK_RST = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (UART_TX !== 1'b1)   begin bad++; $display("FAIL reset_tx got=%b want=1", UART_TX); end
        total++; if (Uart_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Uart_Busy); end
        total++; if (Uart_Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Uart_Done); end
        total++; if (Uart_Drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", Uart_Drop); end
    endtask

    task automatic test_single();
        vec_t m, e_tx, e_busy, e_done;
        send_pulse(8'h01);
        capture(FRAME + 1, -1, 8'h00, 1'b0, 1'b0);
        m      = mask_n(FRAME + 1);
        e_tx   = add_tx('1, 0, 8'h01);
        e_busy = add_busy('0, 0);
        e_done = add_one('0, FRAME - 1);
        total++; if ((tx_v & m) !== (e_tx & m))     begin bad++; $display("FAIL single_tx got=%h want=%h", tx_v & m, e_tx & m); end
        total++; if ((busy_v & m) !== (e_busy & m)) begin bad++; $display("FAIL single_busy got=%h want=%h", busy_v & m, e_busy & m); end
        total++; if ((done_v & m) !== (e_done & m)) begin bad++; $display("FAIL single_done got=%h want=%h", done_v & m, e_done & m); end
        total++; if ((drop_v & m) !== '0)           begin bad++; $display("FAIL single_drop got=%h want=0", drop_v & m); end
    endtask

    task automatic test_drop();
        vec_t m, e_tx, e_busy, e_drop;
        send_pulse(8'h02);
        capture(FRAME + 2, 39, 8'h09, 1'b0, 1'b0);
        m      = mask_n(FRAME + 2);
        e_tx   = add_tx('1, 0, 8'h02);
        e_busy = add_busy('0, 0);
        e_drop = add_one('0, 40);
        total++; if ((tx_v & m) !== (e_tx & m))     begin bad++; $display("FAIL drop_tx got=%h want=%h", tx_v & m, e_tx & m); end
        total++; if ((busy_v & m) !== (e_busy & m)) begin bad++; $display("FAIL drop_busy got=%h want=%h", busy_v & m, e_busy & m); end
        total++; if ((drop_v & m) !== (e_drop & m)) begin bad++; $display("FAIL drop_pulse got=%h want=%h", drop_v & m, e_drop & m); end
    endtask

    task automatic test_back_to_back();
        vec_t m, e_tx, e_busy, e_done, e_drop;
        Uart_En   = 1'b1;
        Uart_Data = 8'h00;
        tick();
        capture(250, -1, 8'h00, 1'b1, 1'b0);
        Uart_En = 1'b0;
        repeat (FRAME + 5) tick();
        m = mask_n(250);
        e_tx = '1; e_busy = '0; e_done = '0; e_drop = '0;
        for (int f = 0; f < 3; f++) begin
            e_tx   = add_tx(e_tx, f * (FRAME + 1), 8'h00);
            e_busy = add_busy(e_busy, f * (FRAME + 1));
            e_done = add_one(e_done, f * (FRAME + 1) + FRAME - 1);
        end
        // Held En is flagged on every edge that finds the line busy.
        for (int i = 1; i < VW; i++) e_drop[i] = e_busy[i - 1];
        total++; if ((tx_v & m) !== (e_tx & m))     begin bad++; $display("FAIL b2b_tx got=%h want=%h", tx_v & m, e_tx & m); end
        total++; if ((busy_v & m) !== (e_busy & m)) begin bad++; $display("FAIL b2b_busy got=%h want=%h", busy_v & m, e_busy & m); end
        total++; if ((done_v & m) !== (e_done & m)) begin bad++; $display("FAIL b2b_done got=%h want=%h", done_v & m, e_done & m); end
        total++; if ((drop_v & m) !== (e_drop & m)) begin bad++; $display("FAIL b2b_drop got=%h want=%h", drop_v & m, e_drop & m); end
    endtask

    task automatic test_reset_mid_frame();
        vec_t m, e_tx, e_busy;
        send_pulse(8'hA5);
        capture(55, -1, 8'h00, 1'b0, 1'b0);
        #2;
        CLK_RST = 1'b0;
        #1;
        total++; if (UART_TX !== 1'b1)   begin bad++; $display("FAIL abort_tx got=%b want=1", UART_TX); end
        total++; if (Uart_Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", Uart_Busy); end
        repeat (3) tick();
        CLK_RST = 1'b1;
        tick();
        capture(FRAME + 10, -1, 8'h00, 1'b0, 1'b0);
        m = mask_n(FRAME + 10);
        total++; if ((done_v & m) !== '0)      begin bad++; $display("FAIL abort_no_done got=%h want=0", done_v & m); end
        total++; if ((busy_v & m) !== '0)      begin bad++; $display("FAIL abort_idle_busy got=%h want=0", busy_v & m); end
        total++; if ((tx_v & m) !== (m))       begin bad++; $display("FAIL abort_idle_tx got=%h want=%h", tx_v & m, m); end
        send_pulse(8'hC3);
        capture(FRAME + 1, -1, 8'h00, 1'b0, 1'b0);
        m      = mask_n(FRAME + 1);
        e_tx   = add_tx('1, 0, 8'hC3);
        e_busy = add_busy('0, 0);
        total++; if ((tx_v & m) !== (e_tx & m))     begin bad++; $display("FAIL after_rst_tx got=%h want=%h", tx_v & m, e_tx & m); end
        total++; if ((busy_v & m) !== (e_busy & m)) begin bad++; $display("FAIL after_rst_busy got=%h want=%h", busy_v & m, e_busy & m); end
    endtask

    task automatic test_data_stable();
        vec_t m, e_tx;
        send_pulse(8'h5A);
        capture(FRAME + 1, -1, 8'h00, 1'b0, 1'b1);
        Uart_Data = 8'h00;
        m    = mask_n(FRAME + 1);
        e_tx = add_tx('1, 0, 8'h5A);
        total++; if ((tx_v & m) !== (e_tx & m)) begin bad++; $display("FAIL scramble_tx got=%h want=%h", tx_v & m, e_tx & m); end
        total++; if (done_v[FRAME - 1] !== 1'b1) begin bad++; $display("FAIL scramble_done got=%b want=1", done_v[FRAME - 1]); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        vec_t m, e_busy;
        m      = mask_n(FRAME + 1);
        e_busy = add_busy('0, 0);
        send_pulse(8'h07);
        capture(FRAME + 1, -1, 8'h00, 1'b0, 1'b0);
        total++; if (tx_v[9 * DIV + 5] !== 1'b1)   begin bad++; $display("FAIL parity_07 got=%b want=1", tx_v[9 * DIV + 5]); end
        total++; if ((busy_v & m) !== (e_busy & m)) begin bad++; $display("FAIL parity_07_busy got=%h want=%h", busy_v & m, e_busy & m); end
        send_pulse(8'h03);
        capture(FRAME + 1, -1, 8'h00, 1'b0, 1'b0);
        total++; if (tx_v[9 * DIV + 5] !== 1'b0)   begin bad++; $display("FAIL parity_03 got=%b want=0", tx_v[9 * DIV + 5]); end
        total++; if ((busy_v & m) !== (e_busy & m)) begin bad++; $display("FAIL parity_03_busy got=%h want=%h", busy_v & m, e_busy & m); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_drop();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_stable();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_byte.md
# uart_tx_byte

Byte-serial UART transmitter that consumes the `Uart_En`/`Uart_Data`/`Uart_Busy` handshake driven by the phase-comparator/PWM control block. It converts each accepted status byte into an asynchronous 8N1 frame on the board TX pin for the host-side logger. It runs entirely on `CLK_SYS` and has no FIFO. Bytes presented while a frame is in flight are dropped and flagged, never queued.

## Interface
- `CLK_FREQ`, default 50_000_000: `CLK_SYS` frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
  - Derived constant `BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD`, rounded to nearest; 434 at defaults.
  - `BAUD_DIV` ≥ 2 is required. Elaboration fails otherwise.
- `CLK_SYS` input, 1: system clock. All logic is rising-edge.
- `CLK_RST` input, 1: reset, asynchronous, active-low.
- `Uart_En` input, 1: byte-valid strobe from the producer. It may be a single-cycle pulse or held high.
- `Uart_Data` input, 8: byte to send. Sampled only in the accept cycle.
- `Uart_Busy` output, 1: high while a frame is in flight. The producer may present a new byte only when this is low.
- `UART_TX` output, 1: serial line. Idle high, LSB first.
- `Uart_Done` output, 1: one-cycle pulse at the end of the stop bit.
- `Uart_Drop` output, 1: one-cycle pulse for each cycle in which `Uart_En`=1 while `Uart_Busy`=1.

## Operation
- Reset values: `UART_TX`=1, `Uart_Busy`=0, `Uart_Done`=0, `Uart_Drop`=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately:
  - `UART_TX` returns to 1 asynchronously.
  - No `Uart_Done` pulse is generated.
- FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE:
  - Accept condition: `Uart_En`=1 and `Uart_Busy`=0 at a rising edge.
  - On accept, `Uart_Data` is latched into the shift register, the baud counter is cleared and the FSM moves to START.
- START: `UART_TX`=0 for `BAUD_DIV` cycles.
- DATA:
  - 8 bits are sent, bit 0 first, each for `BAUD_DIV` cycles.
  - A 3-bit index counts 0..7. After bit 7 completes, the FSM moves to STOP, or to PARITY when that feature is compiled in.
- STOP: `UART_TX`=1 for `BAUD_DIV` cycles. The last cycle of STOP asserts `Uart_Done` and returns the FSM to IDLE.
- Baud counter:
  - 16-bit, counts 0..`BAUD_DIV`-1.
  - The bit advances when the count equals `BAUD_DIV`-1, and the counter wraps to 0 in that same cycle.
- `Uart_Busy` = (FSM ≠ IDLE), registered.
- `Uart_En` held high continuously:
  - The first byte is accepted. `Uart_Drop` then pulses every cycle for the whole frame.
  - The next byte is accepted in the first IDLE cycle after the frame.
- Simultaneous `Uart_Done` and `Uart_En`: the byte is not accepted in that cycle (Busy is still 1) and `Uart_Drop`=1. It is accepted on the following cycle if `Uart_En` is still high.
- `Uart_Data` changes outside the accept cycle have no effect on the frame in flight.

## Timing
- Accept at edge N:
  - `Uart_Busy`=1 and `UART_TX`=0 (start bit) from cycle N+1.
  - Data bit k occupies cycles N+1+(k+1)·`BAUD_DIV` through N+(k+2)·`BAUD_DIV`.
- Frame length: exactly 10·`BAUD_DIV` cycles of `Uart_Busy`=1, or 11·`BAUD_DIV` with parity.
- `Uart_Done` is high in the last Busy cycle. `Uart_Busy` falls on the next edge.
- Minimum idle between back-to-back frames: 1 cycle of IDLE, so the effective stop bit is `BAUD_DIV`+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP for `BAUD_DIV` cycles, carrying the even-parity bit (XOR of the 8 data bits).
  - Frame becomes 8E1, 11·`BAUD_DIV` cycles.
- `UART_TX_PARITY_EN` undefined: the PARITY state and parity logic are absent. Frame is 8N1, 10·`BAUD_DIV` cycles.

## Test plan
All scenarios use `CLK_FREQ`=50_000_000 and `BAUD`=5_000_000, giving `BAUD_DIV`=10.

- Reset, then a single 1-cycle `Uart_En` with `Uart_Data`=8'h01:
  - `UART_TX` = 0 for 10 cycles, then bits 1,0,0,0,0,0,0,0 at 10 cycles each, then 1 for 10 cycles.
  - `Uart_Busy` high for exactly 100 cycles; `Uart_Done` pulses in Busy cycle 100.
- Pulse `Uart_En` with 8'h02 at cycle 0, and again with 8'h09 at cycle 40:
  - Only 8'h02 is transmitted.
  - `Uart_Drop` pulses once, at cycle 40.
- Hold `Uart_En`=1 with 8'h00 for 250 cycles:
  - Frames start at cycles 1 and 102; the third frame starts at 203. Frames are separated by exactly 1 IDLE cycle.
  - `Uart_Drop`=1 in every Busy cycle.
- Reset asserted at cycle 55 of a frame carrying 8'hA5:
  - `UART_TX`=1 and `Uart_Busy`=0 immediately.
  - No `Uart_Done` pulse.
  - A new byte sent after reset release is framed correctly.
- With `UART_TX_PARITY_EN` defined, send 8'h07 and then 8'h03:
  - Parity bit is 1 for 8'h07 and 0 for 8'h03.
  - `Uart_Busy` is high for 110 cycles per frame.
- Change `Uart_Data` every cycle during a frame of 8'h5A: the serialized bits still equal 8'h5A.
